// File: rtl/icache_direct_mapped_if.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped_if
// Bus bundle for the direct-mapped instruction cache.
//   Fetch side : i_read, i_addr (word address), i_data, i_stall, flush
//   Memory side: mem_req, mem_addr (line aligned), mem_ready, mem_rdata (line)
// Modports:
//   slave  - the cache itself (serves fetches, issues line requests)
//   master - the environment (PC stage plus memory)
// -----------------------------------------------------------------------------
interface icache_direct_mapped_if #(
    parameter int OFFSET_BITS = 2,
    parameter int DATA_W      = 16
);
    localparam int LINE_W = DATA_W << OFFSET_BITS;

    logic              i_read;
    logic [15:0]       i_addr;
    logic [DATA_W-1:0] i_data;
    logic              i_stall;
    logic              flush;
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  i_read, i_addr, flush, mem_ready, mem_rdata,
        output i_data, i_stall, mem_req, mem_addr
    );

    modport master (
        output i_read, i_addr, flush, mem_ready, mem_rdata,
        input  i_data, i_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
// Direct-mapped, read-only instruction cache between the PC and memory.
// Hits return the word combinationally in the same cycle; a miss raises
// i_stall immediately and fetches the whole line over a req/ready handshake.
//
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   bus      - icache_direct_mapped_if.slave (fetch + memory line port)
//   hit_count, miss_count - saturating lookup counters (only with
//              ICACHE_STATS_EN defined)
//
// Optional feature macro: ICACHE_STATS_EN
// -----------------------------------------------------------------------------
module icache_direct_mapped #(
    parameter int INDEX_BITS  = 2,
    parameter int OFFSET_BITS = 2,
    parameter int DATA_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    icache_direct_mapped_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int WORDS  = 1 << OFFSET_BITS;
    localparam int LINE_W = DATA_W << OFFSET_BITS;
    localparam int TAG_W  = 16 - INDEX_BITS - OFFSET_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [LINES-1:0]       valid_reg;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [LINE_W-1:0]      data_mem [LINES];

    logic [TAG_W-1:0]       miss_tag_reg;
    logic [INDEX_BITS-1:0]  miss_index_reg;
    logic                   flush_pending_reg;

    logic [OFFSET_BITS-1:0] req_offset;
    logic [INDEX_BITS-1:0]  req_index;
    logic [TAG_W-1:0]       req_tag;
    logic [LINE_W-1:0]      hit_line;
    logic [DATA_W-1:0]      hit_words [WORDS];
    logic                   hit;
    logic                   lookup_hit;
    logic                   lookup_miss;
    logic                   fill_en;

    assign req_offset = bus.i_addr[OFFSET_BITS-1:0];
    assign req_index  = bus.i_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_tag    = bus.i_addr[15 -: TAG_W];

    assign hit_line = data_mem[req_index];
    assign hit      = valid_reg[req_index] && (tag_mem[req_index] == req_tag);

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign hit_words[gi] = hit_line[gi*DATA_W +: DATA_W];
    end

    // Lookups only happen in IDLE; reset_n gates them so an asserted reset
    // shows no stall and latches nothing even while i_read is high.
    assign lookup_hit  = reset_n && (state_reg == IDLE) && bus.i_read && hit;
    assign lookup_miss = reset_n && (state_reg == IDLE) && bus.i_read && !hit;

    always_comb begin
        state_next   = state_reg;
        fill_en      = 1'b0;
        bus.i_stall  = 1'b0;
        bus.i_data   = '0;
        bus.mem_req  = 1'b0;
        bus.mem_addr = '0;
        case (state_reg)
            IDLE: begin
                if (lookup_hit) begin
                    bus.i_data = hit_words[req_offset];
                end
                if (lookup_miss) begin
                    bus.i_stall = 1'b1;
                    state_next  = MISS;
                end
            end
            MISS: begin
                // i_addr is not looked at here: the PC is frozen and the
                // line to fetch comes from the latched miss tag/index.
                bus.mem_req  = 1'b1;
                bus.mem_addr = {miss_tag_reg, miss_index_reg, {OFFSET_BITS{1'b0}}};
                bus.i_stall  = 1'b1;
                if (bus.mem_ready) begin
                    fill_en    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            miss_tag_reg      <= '0;
            miss_index_reg    <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (lookup_miss) begin
                miss_tag_reg   <= req_tag;
                miss_index_reg <= req_index;
            end
            // A flush while the fill is outstanding must poison that fill.
            if (fill_en) begin
                flush_pending_reg <= 1'b0;
            end else if ((state_reg == MISS) && bus.flush) begin
                flush_pending_reg <= 1'b1;
            end
        end
    end

    // Line payload and tag carry no reset; valid_reg alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[miss_index_reg] <= bus.mem_rdata;
            tag_mem[miss_index_reg]  <= miss_tag_reg;
        end
    end

    // Per-line valid bit. A fill coinciding with (or preceded by) a flush
    // in the same miss is written invalid so stale data is never served.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_reg[gi] <= 1'b0;
            end else if (fill_en && (miss_index_reg == INDEX_BITS'(gi))) begin
                valid_reg[gi] <= !(flush_pending_reg || bus.flush);
            end else if (bus.flush) begin
                valid_reg[gi] <= 1'b0;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // One count per IDLE lookup; stall cycles of a miss are not recounted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (lookup_miss && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// tb_icache_direct_mapped
// Self-checking bench for icache_direct_mapped. Scenario tasks drive fetches
// through a generic fetch task and compare against constants and against a
// behavioural cache model (per-index valid/tag, data from a static memory
// function). Counters are checked when ICACHE_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_icache_direct_mapped;
    localparam int INDEX_BITS  = 2;
    localparam int OFFSET_BITS = 2;
    localparam int DATA_W      = 16;
    localparam int LINE_W      = DATA_W << OFFSET_BITS;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    icache_direct_mapped_if #(.OFFSET_BITS(OFFSET_BITS), .DATA_W(DATA_W)) bus ();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    icache_direct_mapped #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .DATA_W     (DATA_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        stall0;
        logic [15:0] data0;
        logic        req0;
        logic [15:0] maddr;
        logic [7:0]  bad_wait;
        logic        stall1;
        logic [15:0] data1;
        logic        req1;
    } obs_t;

    // ---------------- behavioural model ----------------
    bit m_valid [4];
    int m_tag   [4];
    int m_hits;
    int m_misses;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        int ai;
        ai = int'(a);
        if (ai / 4 == 16) return 16'((ai % 4 + 1) * 16'h1110);
        return 16'(ai * 16'h9E37) ^ 16'hC3A5;
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [15:0] a);
        logic [LINE_W-1:0] l;
        int base;
        base = (int'(a) / 4) * 4;
        l = '0;
        for (int w = 0; w < 4; w++) l[w*16 +: 16] = word_at(16'(base + w));
        return l;
    endfunction

    function automatic bit model_hit(input logic [15:0] a);
        int ai;
        ai = int'(a);
        return m_valid[(ai / 4) % 4] && (m_tag[(ai / 4) % 4] == ai / 16);
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_step(input logic [15:0] a, input bit fl, input int fm,
                                       output bit h0, output bit h1);
        int ai;
        ai = int'(a);
        h0 = model_hit(a);
        if (h0) m_hits++; else m_misses++;
        if (fl) model_flush();
        if (!h0) begin
            if (fm >= 0) model_flush();
            m_valid[(ai / 4) % 4] = (fm < 0);
            m_tag[(ai / 4) % 4]   = ai / 16;
        end
        h1 = model_hit(a);
    endfunction

    // ---------------- stimulus tasks ----------------
    // One fetch transaction. On a miss, memory answers after `delay` MISS
    // cycles; `fm` is the MISS cycle index carrying a flush (-1 = none).
    task automatic fetch(input logic [15:0] a, input int delay, input bit fl,
                         input int fm, output obs_t o);
        o = '0;
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = a; bus.flush = fl; bus.mem_ready = 1'b0;
        #1;
        o.stall0 = bus.i_stall; o.data0 = bus.i_data; o.req0 = bus.mem_req;
        if (!o.stall0) begin
            @(posedge clk);
            #1;
            bus.i_read = 1'b0; bus.flush = 1'b0;
            o.stall1 = o.stall0; o.data1 = o.data0; o.req1 = bus.mem_req;
            $display("fetch addr=%h hit data=%h req_after=%0d", a, o.data0, o.req1);
            return;
        end
        @(posedge clk);
        for (int k = 0; k <= delay; k++) begin
            @(negedge clk);
            bus.i_addr    = 16'($urandom);
            bus.flush     = (k == fm);
            bus.mem_ready = (k == delay);
            bus.mem_rdata = (k == delay) ? line_of(a) : {$urandom, $urandom};
            #1;
            if (k == 0) o.maddr = bus.mem_addr;
            if (bus.mem_req !== 1'b1 || bus.i_stall !== 1'b1 || bus.i_data !== 16'h0 ||
                bus.mem_addr !== (a & 16'hFFFC))
                o.bad_wait = o.bad_wait + 8'd1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.flush = 1'b0; bus.i_addr = a;
        #1;
        o.stall1 = bus.i_stall; o.data1 = bus.i_data; o.req1 = bus.mem_req;
        bus.i_read = 1'b0;
        @(posedge clk);
        $display("fetch addr=%h miss mem_addr=%h wait=%0d fm=%0d after: stall=%0d data=%h",
                 a, o.maddr, delay, fm, o.stall1, o.data1);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.i_read = 1'b0; bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        $display("flush pulse");
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.i_read = 1'b0; bus.i_addr = '0; bus.flush = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 16'h0042;
        #1;
        checks++; if (bus.i_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.i_stall); end
        checks++; if (bus.i_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.i_data); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_maddr got=%h exp=0000", bus.mem_addr); end
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++;
            $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
`endif
        @(negedge clk);
        bus.i_read = 1'b0; reset_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_cold_miss();
        obs_t o; bit h0, h1;
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 3, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL cold_stall_same_cycle got=%b exp=1", o.stall0); end
        checks++; if (o.data0 !== 16'h0) begin errors++; $display("FAIL cold_data_during_miss got=%h exp=0000", o.data0); end
        checks++; if (o.maddr !== 16'h0040) begin errors++; $display("FAIL cold_mem_addr got=%h exp=0040", o.maddr); end
        checks++; if (o.bad_wait !== 8'd0) begin errors++; $display("FAIL cold_wait_cycles got=%0d bad cycles exp=0", o.bad_wait); end
        checks++; if (o.stall1 !== 1'b0) begin errors++; $display("FAIL cold_stall_after_fill got=%b exp=0", o.stall1); end
        checks++; if (o.data1 !== 16'h3330) begin errors++; $display("FAIL cold_data_after_fill got=%h exp=3330", o.data1); end
        checks++; if (o.req1 !== 1'b0) begin errors++; $display("FAIL cold_req_dropped got=%b exp=0", o.req1); end
    endtask

    task automatic test_spatial_hit();
        obs_t o; bit h0, h1;
        model_step(16'h0043, 1'b0, -1, h0, h1);
        fetch(16'h0043, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b0) begin errors++; $display("FAIL spatial_stall got=%b exp=0", o.stall0); end
        checks++; if (o.data0 !== 16'h4440) begin errors++; $display("FAIL spatial_data got=%h exp=4440", o.data0); end
        checks++; if (o.req0 !== 1'b0 || o.req1 !== 1'b0) begin errors++;
            $display("FAIL spatial_req got=%b%b exp=00", o.req0, o.req1); end
    endtask

    task automatic test_conflict();
        obs_t o; bit h0, h1;
        model_step(16'h0000, 1'b0, -1, h0, h1);
        fetch(16'h0000, 1, 1'b0, -1, o);
        checks++; if (o.data1 !== word_at(16'h0000)) begin errors++;
            $display("FAIL conflict_fill0 got=%h exp=%h", o.data1, word_at(16'h0000)); end
        model_step(16'h0010, 1'b0, -1, h0, h1);
        fetch(16'h0010, 2, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL conflict_wrap_miss got=%b exp=1", o.stall0); end
        checks++; if (o.maddr !== 16'h0010) begin errors++; $display("FAIL conflict_wrap_addr got=%h exp=0010", o.maddr); end
        checks++; if (o.data1 !== word_at(16'h0010)) begin errors++;
            $display("FAIL conflict_wrap_data got=%h exp=%h", o.data1, word_at(16'h0010)); end
        model_step(16'h0000, 1'b0, -1, h0, h1);
        fetch(16'h0000, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL conflict_evicted got=%b exp=1", o.stall0); end
    endtask

    task automatic test_flush_idle();
        obs_t o; bit h0, h1;
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 1, 1'b0, -1, o);
        checks++; if (o.data1 !== 16'h3330) begin errors++; $display("FAIL flush_refill got=%h exp=3330", o.data1); end
        flush_pulse();
        model_flush();
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL flush_idle_miss got=%b exp=1", o.stall0); end
        model_step(16'h0042, 1'b1, -1, h0, h1);
        fetch(16'h0042, 0, 1'b1, -1, o);
        checks++; if (o.stall0 !== 1'b0 || o.data0 !== 16'h3330) begin errors++;
            $display("FAIL flush_same_cycle_hit got=stall %b data %h exp=stall 0 data 3330", o.stall0, o.data0); end
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL flush_same_cycle_after got=%b exp=1", o.stall0); end
    endtask

    task automatic test_flush_miss();
        obs_t o; bit h0, h1;
        flush_pulse();
        model_flush();
        model_step(16'h0042, 1'b0, 0, h0, h1);
        fetch(16'h0042, 2, 1'b0, 0, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL flush_miss_enter got=%b exp=1", o.stall0); end
        checks++; if (o.stall1 !== 1'b1 || o.data1 !== 16'h0) begin errors++;
            $display("FAIL flush_miss_fill_invalid got=stall %b data %h exp=stall 1 data 0000", o.stall1, o.data1); end
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL flush_miss_remiss got=%b exp=1", o.stall0); end
        checks++; if (o.stall1 !== 1'b0 || o.data1 !== 16'h3330) begin errors++;
            $display("FAIL flush_miss_recover got=stall %b data %h exp=stall 0 data 3330", o.stall1, o.data1); end
        model_step(16'h0021, 1'b0, 1, h0, h1);
        fetch(16'h0021, 1, 1'b0, 1, o);
        checks++; if (o.stall1 !== 1'b1) begin errors++; $display("FAIL flush_with_ready got=%b exp=1", o.stall1); end
        model_step(16'h0021, 1'b0, -1, h0, h1);
        fetch(16'h0021, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL flush_with_ready_remiss got=%b exp=1", o.stall0); end
    endtask

    task automatic test_ready_in_idle();
        obs_t o; bit h0, h1;
        @(negedge clk);
        bus.i_read = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = {$urandom, $urandom};
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.i_stall !== 1'b0) begin errors++;
            $display("FAIL ready_idle_quiet got=req %b stall %b exp=0 0", bus.mem_req, bus.i_stall); end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        model_step(16'h0021, 1'b0, -1, h0, h1);
        fetch(16'h0021, 0, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b0 || o.data0 !== word_at(16'h0021)) begin errors++;
            $display("FAIL ready_idle_untouched got=stall %b data %h exp=stall 0 data %h", o.stall0, o.data0, word_at(16'h0021)); end
    endtask

    task automatic test_reset_mid_miss();
        obs_t o; bit h0, h1;
        flush_pulse();
        model_flush();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 16'h0033; bus.mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmiss_req_before got=%b exp=1", bus.mem_req); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.i_stall !== 1'b0) begin errors++;
            $display("FAIL rstmiss_immediate got=req %b stall %b exp=0 0", bus.mem_req, bus.i_stall); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rstmiss_addr got=%h exp=0000", bus.mem_addr); end
        bus.mem_ready = 1'b1; bus.mem_rdata = line_of(16'h0033);
        @(posedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0; bus.i_read = 1'b0; reset_n = 1'b1;
        model_reset();
        $display("reset pulse mid-miss");
        model_step(16'h0042, 1'b0, -1, h0, h1);
        fetch(16'h0042, 1, 1'b0, -1, o);
        checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL rstmiss_cold_after got=%b exp=1", o.stall0); end
        checks++; if (o.data1 !== 16'h3330) begin errors++; $display("FAIL rstmiss_fill got=%h exp=3330", o.data1); end
    endtask

    task automatic test_random();
        obs_t o; bit h0, h1;
        logic [15:0] a;
        int dly, fm;
        bit fl;
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 16'h8000;
            dly = int'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 5) == 0);
            fm  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, dly)) : -1;
            model_step(a, fl, fm, h0, h1);
            fetch(a, dly, fl, fm, o);
            checks++; if (o.stall0 !== !h0) begin errors++;
                $display("FAIL rand_lookup addr=%h got stall=%b exp=%b", a, o.stall0, !h0); end
            checks++; if (o.data0 !== (h0 ? word_at(a) : 16'h0)) begin errors++;
                $display("FAIL rand_data addr=%h got=%h exp=%h", a, o.data0, h0 ? word_at(a) : 16'h0); end
            if (!h0) begin
                checks++; if (o.maddr !== (a & 16'hFFFC) || o.bad_wait !== 8'd0) begin errors++;
                    $display("FAIL rand_request addr=%h got maddr=%h bad=%0d exp maddr=%h bad=0", a, o.maddr, o.bad_wait, a & 16'hFFFC); end
                checks++; if (o.stall1 !== !h1 || o.data1 !== (h1 ? word_at(a) : 16'h0) || o.req1 !== 1'b0) begin errors++;
                    $display("FAIL rand_after_fill addr=%h got stall=%b data=%h req=%b exp stall=%b data=%h req=0",
                             a, o.stall1, o.data1, o.req1, !h1, h1 ? word_at(a) : 16'h0); end
            end
        end
`ifdef ICACHE_STATS_EN
        checks++; if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses)) begin errors++;
            $display("FAIL rand_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, m_hits, m_misses); end
`endif
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        obs_t o; bit h0, h1;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            model_step(16'(16'h0040 + i), 1'b0, -1, h0, h1);
            fetch(16'(16'h0040 + i), 1, 1'b0, -1, o);
        end
        checks++; if (hit_count !== 16'd3) begin errors++; $display("FAIL stats_hits got=%0d exp=3", hit_count); end
        checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL stats_misses got=%0d exp=1", miss_count); end
        flush_pulse();
        checks++; if (hit_count !== 16'd3 || miss_count !== 16'd1) begin errors++;
            $display("FAIL stats_flush_kept got=%0d/%0d exp=3/1", hit_count, miss_count); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_flush_idle();
        test_flush_miss();
        test_ready_in_idle();
        test_reset_mid_miss();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
